// File: rtl/jk_ff_bank.sv
// jk_ff_bank: a bank of WIDTH independent flip-flops with a shared mode select.
// Each bit can behave as a JK, T, D or SR flip-flop. The bank also provides
// per-bit enables, a parallel load, a sticky flag for S=R=1 in SR mode and a
// saturating count of the edges on which the stored value changed.
// Everything is clocked by clk. The reset is synchronous and active-low.
module jk_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             sr_err,
    output logic [CNT_W-1:0] chg_cnt
);

    // Mode encodings. All bits share one mode.
    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    // The change counter stops at its all-ones value.
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             sr_err_q;
    logic             sr_err_d;
    logic [CNT_W-1:0] chg_cnt_q;
    logic [CNT_W-1:0] chg_cnt_d;

    // Next value and illegal-SR indication produced by each bit's mode logic.
    logic [WIDTH-1:0] bit_next;
    logic [WIDTH-1:0] bit_illegal;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            logic nxt;
            logic ill;

            // Next state of one bit. A disabled bit always holds, and it can
            // never report an illegal SR input.
            always_comb begin
                nxt = state_q[gi];
                ill = 1'b0;
                if (en[gi]) begin
                    case (mode)
                        MODE_JK: begin
                            case ({j[gi], k[gi]})
                                2'b01:   nxt = 1'b0;
                                2'b10:   nxt = 1'b1;
                                2'b11:   nxt = ~state_q[gi];
                                default: nxt = state_q[gi];
                            endcase
                        end
                        MODE_T: begin
                            nxt = j[gi] ? ~state_q[gi] : state_q[gi];
                        end
                        MODE_D: begin
                            nxt = j[gi];
                        end
                        MODE_SR: begin
                            case ({j[gi], k[gi]})
                                2'b10:   nxt = 1'b1;
                                2'b01:   nxt = 1'b0;
                                2'b11: begin
                                    nxt = state_q[gi];
                                    ill = 1'b1;
                                end
                                default: nxt = state_q[gi];
                            endcase
                        end
                        default: nxt = state_q[gi];
                    endcase
                end
            end

            assign bit_next[gi]    = nxt;
            assign bit_illegal[gi] = ill;
        end
    endgenerate

    // Load overrides the mode logic for the whole register. The error flag
    // is only set when no load is active. Setting the flag wins over err_clr.
    always_comb begin
        logic sr_set;
        state_d  = load ? load_data : bit_next;
        sr_set   = (mode == MODE_SR) && !load && (|bit_illegal);
        sr_err_d = sr_set | (sr_err_q & ~err_clr);
    end

    // Count the edges on which the register value actually changes. Loading
    // the value that is already stored does not count as a change.
    always_comb begin
        chg_cnt_d = chg_cnt_q;
        if ((state_d != state_q) && (chg_cnt_q != CNT_MAX)) begin
            chg_cnt_d = chg_cnt_q + CNT_ONE;
        end
    end

    // State registers. Reset is sampled on the clock edge and beats every
    // other input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RST_VAL;
            sr_err_q  <= 1'b0;
            chg_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            sr_err_q  <= sr_err_d;
            chg_cnt_q <= chg_cnt_d;
        end
    end

    assign q       = state_q;
    assign qn      = ~state_q;
    assign sr_err  = sr_err_q;
    assign chg_cnt = chg_cnt_q;

endmodule

// File: doc/jk_ff_bank.md
# jk_ff_bank

Parametrised bank of WIDTH independent flip-flops built around the JK/toggle core. Each bit can operate as JK, T, D or SR under a shared mode select, with per-bit enable, parallel load, a sticky illegal-SR flag and a saturating change counter. It is the general-purpose storage element for the sequential designs in this library, replacing single-bit JK/T instances where a register-width, mode-selectable flip-flop is needed.

## Interface
- WIDTH, 8, number of flip-flop bits (1..64)
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset
- CNT_W, 8, width of the change counter (2..32)

- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-low reset (sampled on rising clk)
- mode  input  2  00 = JK, 01 = T, 10 = D, 11 = SR (shared by all bits)
- en  input  WIDTH  per-bit clock enable; 0 = bit holds
- j  input  WIDTH  J (JK), T (T), D (D) or S (SR)
- k  input  WIDTH  K (JK) or R (SR); ignored in T and D modes
- load  input  1  parallel load strobe
- load_data  input  WIDTH  value written on load
- err_clr  input  1  clears sr_err
- q  output  WIDTH  registered state
- qn  output  WIDTH  ~q (combinational from q)
- sr_err  output  1  sticky: SR mode saw S=R=1 on an enabled bit
- chg_cnt  output  CNT_W  number of clock edges on which q changed, saturating

## Operation
- Priority per edge: reset low > load > per-bit mode logic.
- reset low: q <= RST_VAL, sr_err <= 0, chg_cnt <= 0; all other inputs ignored.
- load high: q <= load_data for all bits regardless of en and mode; sr_err unaffected except by err_clr.
- Otherwise, for each bit i with en[i]=1:
  - JK: 00 hold, 01 (J=0,K=1) clear, 10 set, 11 toggle.
  - T: j[i]=1 toggle, 0 hold.
  - D: q[i] <= j[i].
  - SR: 10 set, 01 clear, 00 hold, 11 hold and flag illegal.
- Bits with en[i]=0 hold in every mode; their j/k never set sr_err.
- sr_err: set on any edge where mode=11, load=0, and some bit has en=j=k=1; stays set until err_clr. Set and err_clr on the same edge: set wins.
- chg_cnt: increments by 1 on every edge where next q != current q (including via load); saturates at 2^CNT_W-1, no wrap. Not incremented when a load writes the current value.
- mode change takes effect on the same edge it is sampled; there is no internal mode state.

## Timing
- All state updates on rising clk; inputs sampled at the edge, q visible after that edge (1-cycle latency).
- qn tracks q with no extra cycle.
- sr_err and chg_cnt update on the same edge as the q change that caused them.
- Reset mid-operation: the next edge with reset low overrides load, err_clr and all mode activity; outputs equal reset values in the following cycle.
- Reset is synchronous: reset asserted between edges has no effect until the next rising clk.
- No combinational path from inputs to outputs.

## Test plan
- Reset: RST_VAL=8'hA5, reset low 2 edges with load=1, load_data=8'hFF -> q=8'hA5, qn=8'h5A, sr_err=0, chg_cnt=0.
- JK sequence, en=8'hFF, from q=8'h00: j=8'h0F,k=0 -> 8'h0F; j=0,k=8'h03 -> 8'h0C; j=k=8'hFF -> 8'hF3; j=k=0 -> 8'hF3, chg_cnt=3.
- Per-bit enable in T mode: q=8'h00, en=8'h55, j=8'hFF for 3 edges -> 8'h55, 8'h00, 8'h55; disabled bits stay 0.
- SR illegal: mode=11, en=8'h01, j=k=8'h01 -> q bit0 unchanged, sr_err=1 next cycle; repeat with en=0 -> no new set; err_clr=1 with another illegal input same edge -> sr_err stays 1; err_clr alone -> 0.
- Load priority and counter: load=1, load_data=8'h3C while mode=D, j=8'hFF -> q=8'h3C; load of 8'h3C again -> chg_cnt unchanged.
- Saturation, CNT_W=2: T mode toggling bit0 for 5 edges -> chg_cnt 1,2,3,3,3.
